// File: rtl/hs_pkg.sv
// hs_pkg: shared FSM state type and default sizing for the handshake transmitter
package hs_pkg;
  typedef enum logic [1:0] {IDLE, SETUP, WAIT_ACK} state_t;
  localparam int DEF_DATA_W = 3;
  localparam int DEF_DEPTH = 4;
  localparam int DEF_SYNC_STAGES = 2;
endpackage

// File: rtl/hs_sync.sv
// hs_sync: multi-flop synchronizer for an asynchronous single-bit input
module hs_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic [STAGES-1:0] ff;
  always_ff @(posedge clk or posedge rst)
    if (rst) ff <= '0;
    else ff <= (ff << 1) | STAGES'(d);
  assign q = ff[STAGES-1];
endmodule

// File: rtl/hs_tx_source.sv
// hs_tx_source: FIFO-buffered producer driving a two-phase bundled-data request/acknowledge channel
module hs_tx_source
  import hs_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH = DEF_DEPTH,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              req_out,
  output logic [DATA_W-1:0] data_out,
  input  logic              ack_in,
  output logic              busy,
  output logic [7:0]        tx_count,
  output logic              err
);
  localparam int AW = $clog2(DEPTH);
  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic empty, full, push, pop, done, spur, ack_s, err_q;
  state_t state, state_nxt;
  hs_sync #(.STAGES(SYNC_STAGES)) u_sync (.clk(clk), .rst(rst), .d(ack_in), .q(ack_s));
  assign empty = wr_ptr == rd_ptr;
  assign full = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  // a pop frees the head slot on this edge, so a full FIFO can still take a word
  assign in_ready = !rst && (!full || pop);
  assign push = in_valid && in_ready;
  assign busy = (state != IDLE) || !empty;
  assign err = err_q || spur;
  always_comb begin
    done = (state == WAIT_ACK) && (ack_s == req_out);
    spur = (state != WAIT_ACK) && (ack_s != req_out);
    pop = !empty && ((state == IDLE) || done);
    state_nxt = pop ? SETUP : (state == SETUP) ? WAIT_ACK : done ? IDLE : state;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nxt;
  always_ff @(posedge clk)
    if (push) mem[wr_ptr[AW-1:0]] <= in_data;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      req_out <= 1'b0;
      data_out <= '0;
      tx_count <= '0;
      err_q <= 1'b0;
    end else begin
      wr_ptr <= wr_ptr + (AW+1)'(push);
      rd_ptr <= rd_ptr + (AW+1)'(pop);
      if (pop) data_out <= mem[rd_ptr[AW-1:0]];
      if (state == SETUP) req_out <= ~req_out;
      if (done) tx_count <= tx_count + 8'd1;
      if (spur) err_q <= 1'b1;
    end
endmodule

// File: tb/tb_hs_tx_source.sv
// tb_hs_tx_source: directed vector table plus handshake scenarios with an ack responder and scoreboard
module tb_hs_tx_source;
  localparam int RDLY = 3;
  logic clk = 0, rst = 1, in_valid = 0, ack_man = 0, manual = 0, resp_en = 0;
  logic [2:0] in_data = '0;
  logic in_ready, req_out, busy, err, ack_in, ack_auto, prev_req;
  logic [2:0] data_out;
  logic [7:0] tx_count;
  int checks = 0, errors = 0, rcnt, toggles;
  logic [2:0] exp_q[$], rcv_q[$];

  typedef struct {
    logic v; logic [2:0] d; logic ack;
    logic req; logic [2:0] dout; logic rdy; logic bsy; logic er; logic [7:0] tx;
  } vec_t;
  vec_t tbl[12];

  hs_tx_source dut (.clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .req_out(req_out), .data_out(data_out), .ack_in(ack_in), .busy(busy), .tx_count(tx_count), .err(err));

  always #5 clk = ~clk;
  assign ack_in = manual ? ack_man : ack_auto;

  always @(negedge clk or posedge rst)
    if (rst) begin
      ack_auto <= 1'b0;
      rcnt <= 0;
    end else if (resp_en && req_out != ack_auto) begin
      if (rcnt == RDLY - 1) begin
        ack_auto <= req_out;
        rcnt <= 0;
      end else rcnt <= rcnt + 1;
    end

  always @(negedge clk or posedge rst)
    if (rst) begin
      prev_req <= 1'b0;
      toggles <= 0;
      rcv_q.delete();
    end else if (req_out != prev_req) begin
      prev_req <= req_out;
      toggles <= toggles + 1;
      rcv_q.push_back(data_out);
    end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset;
    rst = 1;
    in_valid = 0;
    exp_q.delete();
    cyc(1);
    rst = 0;
    cyc(1);
  endtask

  task automatic push_word(input logic [2:0] d);
    int n = 0;
    in_valid = 1;
    in_data = d;
    while (!in_ready && n < 2000) begin
      cyc(1);
      n++;
    end
    if (n >= 2000) chk("push_timeout", 0, 1);
    cyc(1);
    exp_q.push_back(d);
    in_valid = 0;
  endtask

  task automatic wait_done(input int k);
    int n = 0;
    while (!(toggles == k && !busy) && n < 20000) begin
      cyc(1);
      n++;
    end
    chk("drain_timeout", 32'(n < 20000), 1);
  endtask

  task automatic cmp_queues(input string name);
    chk({name, "_size"}, rcv_q.size(), exp_q.size());
    for (int i = 0; i < rcv_q.size() && i < exp_q.size(); i++) chk({name, "_order"}, rcv_q[i], exp_q[i]);
  endtask

  initial begin
    //            v  d  ack req dout rdy bsy er tx
    tbl[0]  = '{1, 5, 0, 0, 0, 1, 1, 0, 0};
    tbl[1]  = '{0, 0, 0, 0, 5, 1, 1, 0, 0};
    tbl[2]  = '{0, 0, 0, 1, 5, 1, 1, 0, 0};
    tbl[3]  = '{0, 0, 1, 1, 5, 1, 1, 0, 0};
    tbl[4]  = '{0, 0, 1, 1, 5, 1, 1, 0, 0};
    tbl[5]  = '{0, 0, 1, 1, 5, 1, 0, 0, 1};
    tbl[6]  = '{0, 0, 1, 1, 5, 1, 0, 0, 1};
    tbl[7]  = '{0, 0, 0, 1, 5, 1, 0, 0, 1};
    tbl[8]  = '{0, 0, 0, 1, 5, 1, 0, 1, 1};
    tbl[9]  = '{0, 0, 0, 1, 5, 1, 0, 1, 1};
    tbl[10] = '{0, 0, 1, 1, 5, 1, 0, 1, 1};
    tbl[11] = '{0, 0, 1, 1, 5, 1, 0, 1, 1};

    cyc(2);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_req", req_out, 0);
    chk("rst_dout", data_out, 0);
    chk("rst_tx", tx_count, 0);
    chk("rst_err", err, 0);
    rst = 0;
    #1;
    chk("rel_in_ready", in_ready, 1);
    cyc(1);

    // single word then spurious ack while idle
    manual = 1;
    for (int i = 0; i < 12; i++) begin
      in_valid = tbl[i].v;
      in_data = tbl[i].d;
      ack_man = tbl[i].ack;
      cyc(1);
      chk($sformatf("v%0d_req", i), req_out, tbl[i].req);
      chk($sformatf("v%0d_dout", i), data_out, tbl[i].dout);
      chk($sformatf("v%0d_rdy", i), in_ready, tbl[i].rdy);
      chk($sformatf("v%0d_busy", i), busy, tbl[i].bsy);
      chk($sformatf("v%0d_err", i), err, tbl[i].er);
      chk($sformatf("v%0d_tx", i), tx_count, tbl[i].tx);
    end
    cyc(5);
    chk("err_sticky", err, 1);
    manual = 0;
    ack_man = 0;
    do_reset;
    chk("err_cleared", err, 0);

    // burst 1..5 with responder
    resp_en = 1;
    for (int i = 1; i <= 5; i++) push_word(3'(i));
    chk("burst_full_hold", in_ready, 0);
    wait_done(5);
    chk("burst_tx", tx_count, 5);
    chk("burst_toggles", toggles, 5);
    cmp_queues("burst");

    // fill to full while stalled, then push coinciding with each pop
    do_reset;
    resp_en = 0;
    for (int i = 2; i <= 6; i++) push_word(3'(i));
    chk("full_ready", in_ready, 0);
    chk("full_toggles", toggles, 1);
    resp_en = 1;
    push_word(3'd7);
    chk("swap1_still_full", in_ready, 0);
    push_word(3'd0);
    chk("swap2_still_full", in_ready, 0);
    wait_done(7);
    chk("full_tx", tx_count, 7);
    cmp_queues("full");

    // reset in WAIT_ACK with two words queued
    push_word(3'd1);
    wait_done(8);
    resp_en = 0;
    push_word(3'd2);
    push_word(3'd3);
    push_word(3'd4);
    cyc(2);
    chk("pre_rst_req", req_out, 1);
    chk("pre_rst_dout", data_out, 2);
    chk("pre_rst_tx", tx_count, 8);
    chk("pre_rst_busy", busy, 1);
    rst = 1;
    #1;
    chk("mid_rst_req", req_out, 0);
    chk("mid_rst_dout", data_out, 0);
    chk("mid_rst_tx", tx_count, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_ready", in_ready, 0);
    exp_q.delete();
    cyc(1);
    rst = 0;
    resp_en = 1;
    cyc(10);
    chk("post_rst_toggles", toggles, 0);
    chk("post_rst_busy", busy, 0);
    chk("post_rst_ready", in_ready, 1);

    // 256 handshakes wrap the counter
    for (int i = 0; i < 256; i++) push_word(3'(i * 3 + i / 8));
    wait_done(256);
    chk("wrap_tx", tx_count, 0);
    chk("wrap_toggles", toggles, 256);
    cmp_queues("wrap");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/hs_tx_source.md
HS_TX_SOURCE -- requirements
Module: hs_tx_source

Interface
REQ-001 Parameter DATA_W, default 3, width of data_out/in_data.
REQ-002 Parameter DEPTH, default 4, FIFO entries; SHALL be a power of two >= 2.
REQ-003 Parameter SYNC_STAGES, default 2, ack_in synchronizer depth.
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 in_valid  input  1  synchronous producer offers in_data.
REQ-007 in_ready  output  1  FIFO can accept a word (= not full).
REQ-008 in_data  input  DATA_W  word to transmit.
REQ-009 req_out  output  1  two-phase request; each toggle = one new word.
REQ-010 data_out  output  DATA_W  bundled data to the asynchronous pipeline input.
REQ-011 ack_in  input  1  two-phase acknowledge from the pipeline; asynchronous to clk.
REQ-012 busy  output  1  high when FIFO non-empty or a handshake is in flight.
REQ-013 tx_count  output  8  completed handshakes, modulo 256.
REQ-014 err  output  1  sticky protocol error.

Function
REQ-015 Push on an edge with in_valid && in_ready; word at tail; no push when full, word not lost (producer holds).
REQ-016 Push and pop on the same edge SHALL be allowed at any occupancy, occupancy unchanged; pointers wrap modulo DEPTH.
REQ-017 ack_in SHALL pass through SYNC_STAGES flops before use (ack_s).
REQ-018 FSM states IDLE, SETUP, WAIT_ACK.
REQ-019 IDLE: FIFO non-empty -> pop head into data_out, go SETUP; empty -> stay.
REQ-020 SETUP: exactly one cycle with data_out stable; on exit req_out toggles, go WAIT_ACK.
REQ-021 WAIT_ACK: when ack_s == req_out the handshake completes: tx_count += 1 (wraps 255->0); FIFO non-empty -> pop into data_out, go SETUP; else go IDLE.
REQ-022 data_out SHALL NOT change during WAIT_ACK or on the edge req_out toggles (bundled-data setup >= 1 clk).
REQ-023 Latency: word accepted on edge N into empty FIFO in IDLE -> data_out valid after edge N+1, req_out toggles at edge N+2.
REQ-024 err SHALL set when ack_s != req_out is seen in IDLE or SETUP (spurious ack), cleared only by rst.
REQ-025 busy = (state != IDLE) || FIFO non-empty.

Reset
REQ-026 rst SHALL immediately force: req_out=0, data_out=0, FIFO empty, in_ready=1 after deassert, state IDLE, tx_count=0, err=0, synchronizer flops=0, busy=0.
REQ-027 Reset mid-handshake SHALL discard FIFO contents and the in-flight word; downstream is reset by the same rst so ack_in returns to 0.
REQ-028 in_ready SHALL be 0 while rst is high.

Structure
REQ-029 Shared package hs_pkg SHALL hold the state enum and the default DATA_W/DEPTH/SYNC_STAGES constants.
REQ-030 One sub-module: hs_sync (SYNC_STAGES-flop synchronizer with async active-high reset to 0); FIFO and FSM are in hs_tx_source.
REQ-031 Size target 120-400 RTL lines.

Verification
REQ-032 Single word: push 3'd5 into empty -> data_out=5 after edge N+1, req_out 0->1 at N+2; ack_in 0->1 -> tx_count=1, busy=0 after sync delay.
REQ-033 Burst: push 1,2,3,4,5 back-to-back with responder toggling ack 3 clks after each req -> in_ready low while 4 held, data_out sequence 1..5, req toggles 5 times, tx_count=5.
REQ-034 Simultaneous push/pop at full (DEPTH=4): occupancy stays 4, order preserved, no word lost or duplicated.
REQ-035 Spurious ack: toggle ack_in while IDLE -> err=1 after SYNC_STAGES edges; stays 1 until rst.
REQ-036 Reset in WAIT_ACK with 2 words queued -> req_out=0, data_out=0, tx_count=0, busy=0 immediately; no further req toggles after release.
REQ-037 Wrap: 256 completed handshakes -> tx_count reads 0, FIFO pointers wrapped 64 times, data order intact.
